// File: rtl/adc_fifo_pkg.sv
// ---------------------------------------------------------------------------
// adc_fifo_pkg
//   Shared definitions for the ADC capture sample FIFO.
//   - Default geometry constants (sample width, depth, almost-full threshold).
//   - Status flag struct. The readout and status-register blocks use the same
//     struct, so the field order here is the bit order they see.
//   - Helper that derives the level-based flags from an occupancy count.
//   Optional build macro: ADC_FIFO_OVWR_EN (see adc_sample_fifo).
// ---------------------------------------------------------------------------
package adc_fifo_pkg;

    localparam int ADC_FIFO_DATA_W    = 12;
    localparam int ADC_FIFO_DEPTH     = 16;
    localparam int ADC_FIFO_AF_THRESH = 12;

    typedef struct packed {
        logic full;
        logic almost_full;
        logic empty;
        logic overflow;
        logic underflow;
    } adc_fifo_flags_t;

    // Flag state after reset or a flush: only EMPTY is set.
    localparam adc_fifo_flags_t ADC_FIFO_FLAGS_RESET = '{
        full:        1'b0,
        almost_full: 1'b0,
        empty:       1'b1,
        overflow:    1'b0,
        underflow:   1'b0
    };

    // Level-derived flags for a given occupancy. The sticky error bits are
    // carried through unchanged from the caller.
    function automatic adc_fifo_flags_t adc_fifo_level_flags(
        input int   level,
        input int   depth,
        input int   af_thresh,
        input logic overflow,
        input logic underflow
    );
        adc_fifo_flags_t f;
        f.full        = (level == depth);
        f.almost_full = (level >= af_thresh);
        f.empty       = (level == 0);
        f.overflow    = overflow;
        f.underflow   = underflow;
        return f;
    endfunction

endpackage

// File: rtl/adc_fifo_tpram.sv
// ---------------------------------------------------------------------------
// adc_fifo_tpram
//   Inferred simple dual-port RAM for the sample FIFO: one write port and one
//   registered read port, both on clk. Read-first: when the read and write
//   addresses match in the same cycle, the read returns the old word.
//   The storage array has no reset so it maps onto block RAM; only the read
//   output register is cleared by rst_n, giving a defined rd_data after reset.
//   The read register only loads when rd_en is high, so rd_data holds its
//   last value between reads.
// Ports
//   clk      in   1        clock, rising edge
//   rst_n    in   1        asynchronous active-low reset (read register only)
//   wr_en    in   1        write strobe
//   wr_addr  in   ADDR_W   write address
//   wr_data  in   DATA_W   write data
//   rd_en    in   1        read strobe; loads rd_data on the next edge
//   rd_addr  in   ADDR_W   read address
//   rd_data  out  DATA_W   registered read data
// ---------------------------------------------------------------------------
module adc_fifo_tpram
    import adc_fifo_pkg::*;
#(
    parameter int DATA_W = ADC_FIFO_DATA_W,
    parameter int DEPTH  = ADC_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DATA_W-1:0]        rd_data
);

    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [DATA_W-1:0] rd_data_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Non-blocking read of the array in the same edge as the write above is
    // what makes a same-address access read-first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_reg <= '0;
        end else if (rd_en) begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/adc_sample_fifo.sv
// ---------------------------------------------------------------------------
// adc_sample_fifo
//   Synchronous sample FIFO between the ADC sample formatter (write side) and
//   the readout/DMA logic (read side). Holds the pointers, the occupancy
//   counter, registered status flags and the rd_valid pipeline bit; storage
//   is in adc_fifo_tpram.
//   Read latency is one cycle: an accepted read presents its word on rd_data
//   with rd_valid high on the following cycle. There is no fall-through.
//   Flags are registered and come from the level counter, so the flags seen
//   at the start of a cycle decide whether that cycle's requests are taken.
// Build option
//   ADC_FIFO_OVWR_EN defined   : ring-buffer mode. A write while full is
//                                accepted and drops the oldest entry.
//   ADC_FIFO_OVWR_EN undefined : a write while full is dropped.
//   In both modes a write while full sets the sticky overflow flag.
// Parameters
//   DATA_W     sample width (1..18)
//   DEPTH      entries, power of two (4..1024)
//   AF_THRESH  almost_full when level >= AF_THRESH (1..DEPTH)
// Ports
//   clk          in   1        system clock, rising edge
//   rst_n        in   1        asynchronous active-low reset
//   clr          in   1        synchronous flush of pointers, level, flags
//   wr_en        in   1        write request
//   wr_data      in   DATA_W   sample to write
//   full         out  1        level == DEPTH
//   almost_full  out  1        level >= AF_THRESH
//   rd_en        in   1        read request
//   rd_data      out  DATA_W   read data, valid when rd_valid
//   rd_valid     out  1        pulse one cycle after an accepted read
//   empty        out  1        level == 0
//   level        out  LVL_W    occupancy 0..DEPTH
//   overflow     out  1        sticky: write seen while full
//   underflow    out  1        sticky: read seen while empty
// ---------------------------------------------------------------------------
module adc_sample_fifo
    import adc_fifo_pkg::*;
#(
    parameter int DATA_W    = ADC_FIFO_DATA_W,
    parameter int DEPTH     = ADC_FIFO_DEPTH,
    parameter int AF_THRESH = ADC_FIFO_AF_THRESH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   wr_en,
    input  logic [DATA_W-1:0]      wr_data,
    output logic                   full,
    output logic                   almost_full,
    input  logic                   rd_en,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   rd_valid,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int LVL_W  = ADDR_W + 1;

    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
    localparam logic [LVL_W-1:0]  LVL_ONE = LVL_W'(1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [ADDR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [LVL_W-1:0]  level_reg,  level_next;
    adc_fifo_flags_t   flags_reg,  flags_next;
    logic              rd_valid_reg, rd_valid_next;

    // -----------------------------------------------------------------------
    // Request qualification
    // -----------------------------------------------------------------------
    logic wr_req;       // write request not masked by a flush
    logic rd_req;       // read request not masked by a flush
    logic rd_acc;       // read actually pops an entry this cycle
    logic wr_acc;       // write actually stores into the RAM this cycle
    logic drop_oldest;  // ring-buffer overwrite retires the oldest entry
    logic level_up;
    logic level_down;

    assign wr_req = wr_en & ~clr;
    assign rd_req = rd_en & ~clr;

    // A read on an empty FIFO is refused even if a write arrives in the same
    // cycle: the new word is not visible until it is in the RAM.
    assign rd_acc = rd_req & ~flags_reg.empty;

`ifdef ADC_FIFO_OVWR_EN
    // Writes are always taken. When full and nothing is being read, the
    // write lands on the oldest slot (wr_ptr == rd_ptr when full), so rd_ptr
    // steps past it. When a read is also taken, the read already retires
    // that slot and read-first RAM hands back the old word.
    assign wr_acc      = wr_req;
    assign drop_oldest = wr_req & flags_reg.full & ~rd_acc;
`else
    assign wr_acc      = wr_req & ~flags_reg.full;
    assign drop_oldest = 1'b0;
`endif

    // A ring-buffer overwrite while full leaves the count at DEPTH, so a
    // write only raises the level when the FIFO was not already full.
    assign level_up   = wr_acc & ~rd_acc & ~flags_reg.full;
    assign level_down = rd_acc & ~wr_acc;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        level_next    = level_reg;
        flags_next    = flags_reg;
        rd_valid_next = 1'b0;

        if (clr) begin
            // Flush: RAM contents and rd_data are left alone.
            wr_ptr_next   = '0;
            rd_ptr_next   = '0;
            level_next    = '0;
            flags_next    = ADC_FIFO_FLAGS_RESET;
            rd_valid_next = 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_next = wr_ptr_reg + PTR_ONE;
            end
            if (rd_acc || drop_oldest) begin
                rd_ptr_next = rd_ptr_reg + PTR_ONE;
            end

            if (level_up) begin
                level_next = level_reg + LVL_ONE;
            end else if (level_down) begin
                level_next = level_reg - LVL_ONE;
            end

            flags_next = adc_fifo_level_flags(
                int'(level_next),
                DEPTH,
                AF_THRESH,
                flags_reg.overflow  | (wr_req & flags_reg.full),
                flags_reg.underflow | (rd_req & flags_reg.empty)
            );

            rd_valid_next = rd_acc;
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            flags_reg    <= ADC_FIFO_FLAGS_RESET;
            rd_valid_reg <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            level_reg    <= level_next;
            flags_reg    <= flags_next;
            rd_valid_reg <= rd_valid_next;
        end
    end

    // -----------------------------------------------------------------------
    // Storage
    // -----------------------------------------------------------------------
    adc_fifo_tpram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_reg),
        .wr_data (wr_data),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr_reg),
        .rd_data (rd_data)
    );

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign full        = flags_reg.full;
    assign almost_full = flags_reg.almost_full;
    assign empty       = flags_reg.empty;
    assign overflow    = flags_reg.overflow;
    assign underflow   = flags_reg.underflow;
    assign level       = level_reg;
    assign rd_valid    = rd_valid_reg;

endmodule

// File: tb/tb_adc_sample_fifo.sv
// ---------------------------------------------------------------------------
// tb_adc_sample_fifo
//   Bench for adc_sample_fifo at DATA_W=12, DEPTH=16, AF_THRESH=12.
//   Reference model: a queue of stored samples plus two sticky bits; flags
//   and expected read data are derived from the queue contents. Follows the
//   ADC_FIFO_OVWR_EN build option in the same way as the design.
// ---------------------------------------------------------------------------
module tb_adc_sample_fifo;

    localparam int DW    = 12;
    localparam int DEPTH = 16;
    localparam int AF    = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          full;
    logic          almost_full;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          empty;
    logic [4:0]    level;
    logic          overflow;
    logic          underflow;

    adc_sample_fifo #(
        .DATA_W    (DW),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .full        (full),
        .almost_full (almost_full),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .empty       (empty),
        .level       (level),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // ---------------- reference model ----------------
    int q[$];
    bit m_ov;
    bit m_un;
    bit m_valid;
    int m_data;

    task automatic model_reset();
        q.delete();
        m_ov    = 1'b0;
        m_un    = 1'b0;
        m_valid = 1'b0;
        m_data  = 0;
    endtask

    task automatic model_update(input bit c, input bit w, input int d, input bit r);
        bit was_full;
        bit was_empty;
        bit rd_ok;
        if (c) begin
            q.delete();
            m_ov    = 1'b0;
            m_un    = 1'b0;
            m_valid = 1'b0;
        end else begin
            was_full  = (q.size() == DEPTH);
            was_empty = (q.size() == 0);
            rd_ok     = r && !was_empty;
            if (r && was_empty) m_un = 1'b1;
            if (w && was_full)  m_ov = 1'b1;
            m_valid = rd_ok;
            if (rd_ok) m_data = q.pop_front();
            if (w) begin
                if (!was_full) begin
                    q.push_back(d);
                end else begin
`ifdef ADC_FIFO_OVWR_EN
                    if (!rd_ok) void'(q.pop_front());
                    q.push_back(d);
`endif
                end
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("level",       int'(level),       q.size());
        chk("full",        int'(full),        int'(q.size() == DEPTH));
        chk("almost_full", int'(almost_full), int'(q.size() >= AF));
        chk("empty",       int'(empty),       int'(q.size() == 0));
        chk("overflow",    int'(overflow),    int'(m_ov));
        chk("underflow",   int'(underflow),   int'(m_un));
        chk("rd_valid",    int'(rd_valid),    int'(m_valid));
        chk("rd_data",     int'(rd_data),     m_data);
    endtask

    // One clock of stimulus: drive on the falling edge, sample 1 ns after
    // the rising edge, advance the model, compare.
    task automatic step(input bit c, input bit w, input int d, input bit r);
        int dv;
        dv = d;
        @(negedge clk);
        clr     = c;
        wr_en   = w;
        wr_data = dv[DW-1:0];
        rd_en   = r;
        @(posedge clk);
        #1;
        model_update(c, w, dv & 32'hFFF, r);
        $display("t=%0t clr=%0b wr=%0b wd=%03h rd=%0b | lvl=%0d f=%0b af=%0b e=%0b ov=%0b un=%0b v=%0b rd=%03h",
                 $time, c, w, dv & 32'hFFF, r, level, full, almost_full, empty,
                 overflow, underflow, rd_valid, rd_data);
        check_model();
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit c;
        bit w;
        int d;
        bit r;
        int e_lvl;
        bit e_valid;
        int e_data;
        bit e_empty;
        bit e_ov;
        bit e_un;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int exp_word;

        tbl[0] = '{c:0, w:0, d:'h000, r:1, e_lvl:0, e_valid:0, e_data:'h000, e_empty:1, e_ov:0, e_un:1};
        tbl[1] = '{c:0, w:1, d:'h123, r:1, e_lvl:1, e_valid:0, e_data:'h000, e_empty:0, e_ov:0, e_un:1};
        tbl[2] = '{c:0, w:0, d:'h000, r:1, e_lvl:0, e_valid:1, e_data:'h123, e_empty:1, e_ov:0, e_un:1};
        tbl[3] = '{c:0, w:1, d:'h0AA, r:0, e_lvl:1, e_valid:0, e_data:'h123, e_empty:0, e_ov:0, e_un:1};
        tbl[4] = '{c:0, w:1, d:'h0BB, r:0, e_lvl:2, e_valid:0, e_data:'h123, e_empty:0, e_ov:0, e_un:1};
        tbl[5] = '{c:0, w:1, d:'h0CC, r:1, e_lvl:2, e_valid:1, e_data:'h0AA, e_empty:0, e_ov:0, e_un:1};
        tbl[6] = '{c:1, w:1, d:'h0DD, r:1, e_lvl:0, e_valid:0, e_data:'h0AA, e_empty:1, e_ov:0, e_un:0};
        tbl[7] = '{c:0, w:0, d:'h000, r:1, e_lvl:0, e_valid:0, e_data:'h0AA, e_empty:1, e_ov:0, e_un:1};
        tbl[8] = '{c:1, w:0, d:'h000, r:0, e_lvl:0, e_valid:0, e_data:'h0AA, e_empty:1, e_ov:0, e_un:0};

        // ---- reset ----
        rst_n = 1'b0; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_level", int'(level), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full",  int'(full),  0);
        chk("rst_af",    int'(almost_full), 0);
        chk("rst_valid", int'(rd_valid), 0);
        chk("rst_data",  int'(rd_data), 0);
        chk("rst_flags", int'({overflow, underflow}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- table: empty-side corner cases, clr priority ----
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].c, tbl[i].w, tbl[i].d, tbl[i].r);
            chk($sformatf("tbl%0d_level", i), int'(level),     tbl[i].e_lvl);
            chk($sformatf("tbl%0d_valid", i), int'(rd_valid),  int'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_data",  i), int'(rd_data),   tbl[i].e_data);
            chk($sformatf("tbl%0d_empty", i), int'(empty),     int'(tbl[i].e_empty));
            chk($sformatf("tbl%0d_ov",    i), int'(overflow),  int'(tbl[i].e_ov));
            chk($sformatf("tbl%0d_un",    i), int'(underflow), int'(tbl[i].e_un));
        end

        // ---- fill 16 / drain 16 in order ----
        step(1, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            step(0, 1, i + 1, 0);
            chk($sformatf("fill%0d_af", i), int'(almost_full), int'(i + 1 >= AF));
            chk($sformatf("fill%0d_full", i), int'(full), int'(i == 15));
        end
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 0, 1);
            chk($sformatf("drain%0d_data", i), int'(rd_data), i + 1);
            chk($sformatf("drain%0d_valid", i), int'(rd_valid), 1);
        end
        step(0, 0, 0, 0);
        chk("drain_empty", int'(empty), 1);

        // ---- 17th write while full ----
        step(1, 0, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 1, i + 1, 0);
        step(0, 1, 'hABC, 0);
        chk("ovf_flag",  int'(overflow), 1);
        chk("ovf_level", int'(level), 16);
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 0, 1);
`ifdef ADC_FIFO_OVWR_EN
            exp_word = (i < 15) ? i + 2 : 'hABC;
`else
            exp_word = i + 1;
`endif
            chk($sformatf("ovf_rd%0d", i), int'(rd_data), exp_word);
        end

        // ---- steady write+read at level 5, pointers wrap ----
        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 'h100 + i, 0);
        for (int i = 0; i < 40; i++) begin
            step(0, 1, 'h200 + i, 1);
            chk($sformatf("steady%0d_level", i), int'(level), 5);
        end
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1);

        // ---- clr with level 7 and both sticky flags set ----
        step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        for (int i = 0; i < 17; i++) step(0, 1, 'h300 + i, 0);
        for (int i = 0; i < 9; i++) step(0, 0, 0, 1);
        chk("preclr_level", int'(level), 7);
        chk("preclr_flags", int'({overflow, underflow}), 3);
        step(1, 0, 0, 0);
        chk("clr_level", int'(level), 0);
        chk("clr_empty", int'(empty), 1);
        chk("clr_flags", int'({overflow, underflow}), 0);
        chk("clr_valid", int'(rd_valid), 0);

        // ---- randomized traffic ----
        for (int i = 0; i < 600; i++) begin
            int ph;
            bit c, w, r;
            ph = (i / 40) % 3;
            c = ($urandom_range(0, 99) == 0);
            case (ph)
                0:       begin w = ($urandom_range(0, 9) < 8); r = ($urandom_range(0, 9) < 3); end
                1:       begin w = ($urandom_range(0, 9) < 3); r = ($urandom_range(0, 9) < 8); end
                default: begin w = ($urandom_range(0, 1) == 1); r = ($urandom_range(0, 1) == 1); end
            endcase
            step(c, w, int'($urandom_range(0, 4095)), r);
        end

        // ---- asynchronous reset in the middle of a burst ----
        step(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 'h400 + i, 0);
        @(negedge clk);
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 12'h7E7;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_level", int'(level), 0);
        chk("arst_empty", int'(empty), 1);
        chk("arst_full",  int'(full), 0);
        chk("arst_valid", int'(rd_valid), 0);
        chk("arst_data",  int'(rd_data), 0);
        chk("arst_flags", int'({overflow, underflow, almost_full}), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        step(0, 1, 'h5A5, 0);
        step(0, 1, 'h0F0, 0);
        step(0, 0, 0, 1);
        chk("arst_first_rd", int'(rd_data), 'h5A5);
        step(0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
